// File: rtl/dma_pkg.sv
// Shared DMA types: descriptor and error records, scheduler state encoding.
package dma_pkg;

  localparam int DMA_SCHED_MAX_CH = 8;

  typedef enum logic [1:0] {
    SCH_IDLE,
    SCH_RUN,
    SCH_DONE,
    SCH_ERR
  } sched_st_t;

  typedef enum logic [1:0] {
    DMA_NO_ERR,
    DMA_UNALIGNED_ERR,
    DMA_BUS_ERR,
    DMA_LEN_ERR
  } dma_err_src_t;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic         valid;
    dma_err_src_t src;
    logic [31:0]  addr;
  } s_dma_error_t;

endpackage

// File: rtl/dma_chan_sched_if.sv
// Scheduler <-> read/write streamer link; master is the scheduler side.
interface dma_chan_sched_if;
  import dma_pkg::*;

  // Handshake: a stream valid rises when a job starts and holds while the
  // descriptor is stable; the streamer answers with a one-cycle done pulse,
  // valid drops in that same cycle and never re-asserts within the job.
  // err.valid is a level whose rising edge reports a fault.
  s_dma_desc_t  dma_desc_o;
  logic         rd_stream_valid_o;
  logic         wr_stream_valid_o;
  logic         rd_stream_done_i;
  logic         wr_stream_done_i;
  s_dma_error_t rd_stream_err_i;
  s_dma_error_t wr_stream_err_i;

  modport master (
    output dma_desc_o, rd_stream_valid_o, wr_stream_valid_o,
    input  rd_stream_done_i, wr_stream_done_i, rd_stream_err_i, wr_stream_err_i
  );

  modport slave (
    input  dma_desc_o, rd_stream_valid_o, wr_stream_valid_o,
    output rd_stream_done_i, wr_stream_done_i, rd_stream_err_i, wr_stream_err_i
  );

endinterface

// File: rtl/dma_rr_arb.sv
// Combinational rotating-priority arbiter: first eligible index at or after rr_ptr wins.
module dma_rr_arb #(
  parameter  int NUM_CH = 4,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [CW-1:0]     rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CW-1:0]     grant_idx,
  output logic              grant_vld
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      int j;
      j = (32'(rr_ptr) + k) % NUM_CH;
      if (!grant_vld && eligible[j]) begin
        grant_vld = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = CW'(j);
      end
    end
  end

endmodule

// File: rtl/dma_chan_sched.sv
// DMA channel scheduler: arbitrates descriptors, runs rd/wr streamers, reports done/error.
// Define DMA_SCHED_STRICT_PRIO_EN for fixed lowest-index-wins arbitration.
module dma_chan_sched
  import dma_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        ch_en_i,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  input  s_dma_desc_t [NUM_CH-1:0] ch_desc_i,
  output logic [NUM_CH-1:0]        ch_ready_o,
  output logic [NUM_CH-1:0]        ch_done_o,
  output logic [NUM_CH-1:0]        ch_err_o,
  dma_chan_sched_if.master         strm,
  output s_dma_error_t             dma_error_o,
  output logic                     busy_o,
  output logic [CW-1:0]            cur_ch_o,
  output sched_st_t                state_o
);

  sched_st_t     state_q, state_d;
  logic [NUM_CH-1:0] eligible, grant;
  logic [CW-1:0] grant_idx, arb_ptr, cur_ch_q, next_ch;
  logic          grant_vld;
  logic          rd_seen_q, wr_seen_q, rd_err_q, wr_err_q;
  logic          rd_fin, wr_fin, rd_rise, wr_rise, err_exit;
  logic [3:0]    err_cnt_q;
  s_dma_desc_t   desc_q;
  s_dma_error_t  err_q;

  assign eligible = ch_valid_i & ch_en_i;

  dma_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .eligible  (eligible),
    .rr_ptr    (arb_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign rd_fin   = rd_seen_q | strm.rd_stream_done_i;
  assign wr_fin   = wr_seen_q | strm.wr_stream_done_i;
  assign rd_rise  = strm.rd_stream_err_i.valid & ~rd_err_q;
  assign wr_rise  = strm.wr_stream_err_i.valid & ~wr_err_q;
  assign err_exit = (rd_fin & wr_fin) | (err_cnt_q == 4'hF);
  assign next_ch  = (cur_ch_q == CW'(NUM_CH - 1)) ? '0 : cur_ch_q + 1'b1;

`ifdef DMA_SCHED_STRICT_PRIO_EN
  // Rotating from a fixed zero pointer is exactly lowest-index priority.
  assign arb_ptr = '0;
`else
  logic [CW-1:0] rr_ptr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
    end else if (state_q == SCH_DONE || (state_q == SCH_ERR && err_exit)) begin
      rr_ptr_q <= next_ch;
    end
  end

  assign arb_ptr = rr_ptr_q;
`endif

  always_comb begin
    state_d                = state_q;
    ch_ready_o             = '0;
    ch_done_o              = '0;
    ch_err_o               = '0;
    strm.rd_stream_valid_o = 1'b0;
    strm.wr_stream_valid_o = 1'b0;
    case (state_q)
      SCH_IDLE: begin
        if (grant_vld) begin
          ch_ready_o = grant & {NUM_CH{rstn}};
          state_d    = SCH_RUN;
        end
      end
      SCH_RUN: begin
        strm.rd_stream_valid_o = ~rd_seen_q & ~strm.rd_stream_done_i;
        strm.wr_stream_valid_o = ~wr_seen_q & ~strm.wr_stream_done_i;
        if (rd_rise || wr_rise) begin
          state_d = SCH_ERR;
        end else if (rd_fin && wr_fin) begin
          state_d = SCH_DONE;
        end
      end
      SCH_DONE: begin
        ch_done_o[cur_ch_q] = 1'b1;
        state_d             = SCH_IDLE;
      end
      SCH_ERR: begin
        if (err_exit) begin
          ch_err_o[cur_ch_q] = 1'b1;
          state_d            = SCH_IDLE;
        end
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= SCH_IDLE;
      cur_ch_q  <= '0;
      desc_q    <= '0;
      err_q     <= '0;
      rd_seen_q <= 1'b0;
      wr_seen_q <= 1'b0;
      rd_err_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_err_q <= strm.rd_stream_err_i.valid;
      wr_err_q <= strm.wr_stream_err_i.valid;
      if (state_q == SCH_IDLE && grant_vld) begin
        cur_ch_q <= grant_idx;
        desc_q   <= ch_desc_i[grant_idx];
      end
      // Read-side fault wins when both report in the same cycle.
      if (state_q == SCH_RUN) begin
        if (rd_rise)      err_q <= strm.rd_stream_err_i;
        else if (wr_rise) err_q <= strm.wr_stream_err_i;
      end
      if (state_d == SCH_IDLE) begin
        rd_seen_q <= 1'b0;
        wr_seen_q <= 1'b0;
      end else if (state_q != SCH_IDLE) begin
        if (strm.rd_stream_done_i) rd_seen_q <= 1'b1;
        if (strm.wr_stream_done_i) wr_seen_q <= 1'b1;
      end
      err_cnt_q <= (state_q == SCH_ERR) ? err_cnt_q + 4'd1 : 4'd0;
    end
  end

  assign strm.dma_desc_o = desc_q;
  assign dma_error_o     = err_q;
  assign busy_o          = (state_q != SCH_IDLE);
  assign cur_ch_o        = cur_ch_q;
  assign state_o         = state_q;

endmodule
